// File: rtl/mul_unit_iter.sv
// Iterative signed multiplier: one 8x8 unsigned partial product per cycle, accumulated
// into a 2*WIDTH magnitude, then re-signed in exact (two's) or reduced (ones') encoding.
module mul_unit_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result
);

  localparam int N   = WIDTH / 8;
  localparam int NPP = N * N;
  localparam int CW  = (NPP > 1) ? $clog2(NPP) : 1;
  localparam int SW  = $clog2(2 * WIDTH);

  localparam logic [CW-1:0] NC   = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(NPP - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         r_state;
  logic               r_mode;
  logic               r_sign;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_out_valid;

  logic [WIDTH-1:0]   w_mag_a_in;
  logic [WIDTH-1:0]   w_mag_b_in;
  logic [CW-1:0]      w_i;
  logic [CW-1:0]      w_j;
  logic [CW:0]        w_ij;
  logic [SW-1:0]      w_shamt;
  logic [7:0]         w_chunk_a;
  logic [7:0]         w_chunk_b;
  logic [15:0]        w_pp;
  logic [2*WIDTH-1:0] w_pp_ext;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_final;
  logic               w_last;

  // Magnitude of an operand; exact mode maps -2^(W-1) to 2^(W-1), which still fits W bits.
  function automatic logic [WIDTH-1:0] to_mag(input logic [WIDTH-1:0] x, input logic exact);
    if (!x[WIDTH-1])
      to_mag = x;
    else if (exact)
      to_mag = ~x + WIDTH'(1);
    else
      to_mag = ~x;
  endfunction

  assign w_mag_a_in = to_mag(in_a, in_mode);
  assign w_mag_b_in = to_mag(in_b, in_mode);

  assign w_i        = r_cnt / NC;
  assign w_j        = r_cnt % NC;
  assign w_ij       = {1'b0, w_i} + {1'b0, w_j};
  assign w_shamt    = SW'({w_ij, 3'b000});
  assign w_chunk_a  = r_mag_a[8*w_i +: 8];
  assign w_chunk_b  = r_mag_b[8*w_j +: 8];
  assign w_pp       = 16'(w_chunk_a) * 16'(w_chunk_b);
  assign w_pp_ext   = (2*WIDTH)'(w_pp) << w_shamt;
  assign w_acc_next = r_acc + w_pp_ext;
  assign w_last     = (r_cnt == LAST);

  // Negating a zero magnitude gives zero, so exact mode never produces a negative zero.
  assign w_final = !r_sign ? w_acc_next :
                   (r_mode ? (-w_acc_next) : (~w_acc_next));

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign out_result = r_result;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_sign      <= 1'b0;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mode  <= in_mode;
            r_sign  <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            r_mag_a <= w_mag_a_in;
            r_mag_b <= w_mag_b_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit_iter.sv
// Bench for mul_unit_iter: directed vectors and corner sequences at WIDTH=16,
// randomized ops with random backpressure at WIDTH=32 against an arithmetic model.
module tb_mul_unit_iter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        v16 = 1'b0, mode16 = 1'b0, ordy16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16, ov16;
  logic [31:0] res16;

  logic        v32 = 1'b0, mode32 = 1'b0, ordy32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, ov32;
  logic [63:0] res32;

  int checks = 0;
  int errors = 0;

  mul_unit_iter #(.WIDTH(16)) u16 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_valid(v16), .in_ready(rdy16), .in_mode(mode16), .in_a(a16), .in_b(b16),
    .out_valid(ov16), .out_ready(ordy16), .out_result(res16)
  );

  mul_unit_iter #(.WIDTH(32)) u32 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_valid(v32), .in_ready(rdy32), .in_mode(mode32), .in_a(a32), .in_b(b32),
    .out_valid(ov32), .out_ready(ordy32), .out_result(res32)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Signed product of two w-bit operands in the selected encoding.
  function automatic logic [63:0] model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                        input int w);
    logic [63:0] mask;
    logic [31:0] wm;
    logic [63:0] p;
    longint      xa, xb;
    bit          sa, sb;
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    wm   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    sa   = a[w-1];
    sb   = b[w-1];
    if (m) begin
      xa = sa ? longint'(a) - (longint'(1) << w) : longint'(a);
      xb = sb ? longint'(b) - (longint'(1) << w) : longint'(b);
      p  = 64'(xa * xb);
    end else begin
      p = {32'b0, (sa ? (~a & wm) : a)} * {32'b0, (sb ? (~b & wm) : b)};
      if (sa ^ sb) p = ~p;
    end
    return p & mask;
  endfunction

  task automatic start16(input bit m, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    while (!rdy16 && guard < 100) begin @(posedge clk); #1; guard++; end
    if (guard >= 100) chk("ready16_timeout", 72'(rdy16), 72'd1);
    mode16 = m; a16 = a; b16 = b; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
  endtask

  task automatic wait_out16(output logic [31:0] res, output int lat);
    lat = 1;
    while (!ov16 && lat < 60) begin @(posedge clk); #1; lat++; end
    res = res16;
  endtask

  task automatic op16(input string name, input bit m, input logic [15:0] a,
                      input logic [15:0] b, input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    start16(m, a, b);
    wait_out16(r, lat);
    chk({name, "_lat"}, 72'(lat), 72'd5);
    chk(name, 72'(r), 72'(exp));
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] r;
    int          lat;
    bit          seen;
    logic [31:0] ra, rb;
    logic [63:0] exp64, r64;
    bit          m, o;
    int          guard;

    vecs[0]  = '{1'b1, 16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1]  = '{1'b1, 16'hFFFE, 16'h012C, 32'hFFFF_FDA8};
    vecs[2]  = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000};
    vecs[3]  = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000};
    vecs[4]  = '{1'b0, 16'hFFFE, 16'h0003, 32'hFFFF_FFFC};
    vecs[5]  = '{1'b0, 16'h0000, 16'hFFFF, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 16'h0000, 16'hFFFF, 32'h0000_0000};
    vecs[7]  = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    vecs[8]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    vecs[9]  = '{1'b0, 16'h7FFF, 16'hFFFF, 32'hFFFF_FFFF};
    vecs[10] = '{1'b0, 16'h8000, 16'h8000, 32'h3FFF_0001};
    vecs[11] = '{1'b1, 16'h1234, 16'h0100, 32'h0012_3400};

    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_in_ready16", 72'(rdy16), 72'd1);
    chk("rst_out_valid16", 72'(ov16), 72'd0);
    chk("rst_out_result16", 72'(res16), 72'd0);
    chk("rst_in_ready32", 72'(rdy32), 72'd1);
    chk("rst_out_valid32", 72'(ov32), 72'd0);
    chk("rst_out_result32", 72'(res32), 72'd0);

    for (int k = 0; k < 12; k++)
      op16($sformatf("vec%0d", k), vecs[k].mode, vecs[k].a, vecs[k].b, vecs[k].exp);

    // Backpressure: result held, input side blocked, stray in_valid ignored.
    ordy16 = 1'b0;
    start16(1'b1, 16'h0003, 16'h0005);
    wait_out16(r, lat);
    chk("bp_lat", 72'(lat), 72'd5);
    chk("bp_result", 72'(r), 72'h0000_000F);
    for (int k = 0; k < 10; k++) begin
      v16 = k[0]; a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_hold_valid", 72'(ov16), 72'd1);
      chk("bp_hold_ready", 72'(rdy16), 72'd0);
      chk("bp_hold_result", 72'(res16), 72'h0000_000F);
    end
    v16 = 1'b0;
    ordy16 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 72'(rdy16), 72'd1);
    chk("bp_release_valid", 72'(ov16), 72'd0);
    op16("after_bp", 1'b1, 16'h0002, 16'h0002, 32'h0000_0004);

    // Reset while cnt==2 in CALC drops the operation.
    start16(1'b1, 16'h0102, 16'h0304);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("midrst_in_ready", 72'(rdy16), 72'd1);
    chk("midrst_out_valid", 72'(ov16), 72'd0);
    chk("midrst_out_result", 72'(res16), 72'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ov16) seen = 1'b1;
    end
    chk("midrst_no_result", 72'(seen), 72'd0);
    op16("after_rst", 1'b1, 16'h0007, 16'hFFF7, 32'hFFFF_FFC1);

    // WIDTH=32 randomized ops with random out_ready.
    for (int n = 0; n < 1500; n++) begin
      m = 1'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h0000_0000;
        3: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h0000_0001;
        default: rb = $urandom;
      endcase
      exp64 = model(m, ra, rb, 32);
      guard = 0;
      while (!rdy32 && guard < 100) begin @(posedge clk); #1; guard++; end
      if (guard >= 100) chk("ready32_timeout", 72'(rdy32), 72'd1);
      mode32 = m; a32 = ra; b32 = rb; v32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0;
      a32 = $urandom; b32 = $urandom;
      lat = 1;
      while (!ov32 && lat < 60) begin @(posedge clk); #1; lat++; end
      chk("rand32_lat", 72'(lat), 72'd17);
      chk($sformatf("rand32_m%0d_%h_%h", m, ra, rb), 72'(res32), 72'(exp64));
      r64 = res32;
      guard = 0;
      do begin
        o = 1'($urandom);
        ordy32 = o;
        @(posedge clk); #1;
        guard++;
        if (!o) chk("rand32_hold", {7'd0, ov32, res32}, {7'd0, 1'b1, r64});
      end while (!o && guard < 100);
      ordy32 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
